// File: rtl/reloj_pkg.sv
// Shared types and constants for the real-time clock blocks.
`timescale 1ns/1ps
package reloj_pkg;

  // Editing mode of the clock: running, or editing one of the three fields.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HORA = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEG  = 2'd3
  } estado_edicion_t;

  // Default timing constants, in system clock cycles.
  localparam int REPEAT_DELAY_DEF = 50_000_000;
  localparam int REPEAT_RATE_DEF  = 10_000_000;
  localparam int TIMEOUT_DEF      = 1_000_000_000;
  localparam int BLINK_HALF_DEF   = 25_000_000;

  // Hour display format.
  localparam logic FORMA_24H = 1'b0;
  localparam logic FORMA_12H = 1'b1;

  // Field order when the next button is pressed: hour, minute, second, then back to hour.
  function automatic estado_edicion_t siguiente_campo(input estado_edicion_t e);
    estado_edicion_t s;
    s = SET_HORA;
    case (e)
      SET_HORA: s = SET_MIN;
      SET_MIN:  s = SET_SEG;
      SET_SEG:  s = SET_HORA;
      default:  s = SET_HORA;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pulso_repeticion.sv
// Edge detect plus press-and-hold auto-repeat for a single up/down button.
// 'disparo' is combinational and meant to be registered by the parent.
`timescale 1ns/1ps
module pulso_repeticion
  import reloj_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic en,
  input  logic clr,
  output logic evento,
  output logic disparo
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] FIN_RETARDO  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] FIN_CADENCIA = CNT_W'(REPEAT_RATE - 1);

  logic             prev_q,   prev_d;
  logic             armado_q, armado_d;
  logic             fase_q,   fase_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] limite;

  // A press only counts as a rising edge against the previous sample.
  assign evento = btn & ~prev_q;

  // Repeat sequencing: the press arms the counter, the first reload uses the
  // long delay and every later one the shorter repeat rate.
  always_comb begin
    prev_d   = btn;
    armado_d = armado_q;
    fase_d   = fase_q;
    cnt_d    = cnt_q;
    disparo  = 1'b0;
    limite   = fase_q ? FIN_CADENCIA : FIN_RETARDO;
    if (clr || !en) begin
      armado_d = 1'b0;
      fase_d   = 1'b0;
      cnt_d    = '0;
    end else if (evento) begin
      disparo  = 1'b1;
      armado_d = 1'b1;
      fase_d   = 1'b0;
      cnt_d    = '0;
    end else if (!btn) begin
      armado_d = 1'b0;
      fase_d   = 1'b0;
      cnt_d    = '0;
    end else if (armado_q) begin
      if (cnt_q == limite) begin
        disparo = 1'b1;
        fase_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Previous sample resets high so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= 1'b1;
      armado_q <= 1'b0;
      fase_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      armado_q <= armado_d;
      fase_q   <= fase_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/control_edicion_hora.sv
// Programming-mode controller: turns button levels into field enables,
// step pulses, the 12/24 h select and the blinking edit cursor.
`timescale 1ns/1ps
module control_edicion_hora
  import reloj_pkg::*;
#(
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int BLINK_HALF   = BLINK_HALF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_prog,
  input  logic btn_next,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_formato,
  output logic run,
  output logic en_hora,
  output logic en_min,
  output logic en_seg,
  output logic up,
  output logic down,
  output logic forma,
  output logic cursor
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int BL_W = $clog2(BLINK_HALF);
  localparam logic [TO_W-1:0] TO_FIN = TO_W'(TIMEOUT - 1);
  localparam logic [BL_W-1:0] BL_FIN = BL_W'(BLINK_HALF - 1);

  estado_edicion_t estado_q, estado_d;

  logic prev_prog_q, prev_prog_d;
  logic prev_next_q, prev_next_d;
  logic prev_fmt_q,  prev_fmt_d;
  logic ev_prog, ev_next, ev_fmt;
  logic ev_up, ev_down;
  logic disp_up, disp_down;

  logic en_set, ambos, cambio, timeout_fin;

  logic [TO_W-1:0] timeout_q, timeout_d;
  logic [BL_W-1:0] blink_q,   blink_d;

  logic run_q,     run_d;
  logic en_hora_q, en_hora_d;
  logic en_min_q,  en_min_d;
  logic en_seg_q,  en_seg_d;
  logic up_q,      up_d;
  logic down_q,    down_d;
  logic forma_q,   forma_d;
  logic cursor_q,  cursor_d;

  // Step buttons only act while editing and only when pressed alone.
  assign en_set = (estado_q != RUN);
  assign ambos  = btn_up & btn_down;

  pulso_repeticion #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_up (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_up),
    .en      (en_set & ~ambos),
    .clr     (cambio),
    .evento  (ev_up),
    .disparo (disp_up)
  );

  pulso_repeticion #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_down (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_down),
    .en      (en_set & ~ambos),
    .clr     (cambio),
    .evento  (ev_down),
    .disparo (disp_down)
  );

  // Mode transitions; prog and timeout both win over next.
  always_comb begin
    prev_prog_d = btn_prog;
    prev_next_d = btn_next;
    prev_fmt_d  = btn_formato;
    ev_prog     = btn_prog    & ~prev_prog_q;
    ev_next     = btn_next    & ~prev_next_q;
    ev_fmt      = btn_formato & ~prev_fmt_q;
    timeout_fin = en_set && (timeout_q == TO_FIN);
    estado_d    = estado_q;
    case (estado_q)
      RUN: begin
        if (ev_prog) estado_d = SET_HORA;
      end
      SET_HORA, SET_MIN, SET_SEG: begin
        if (ev_prog || timeout_fin) estado_d = RUN;
        else if (ev_next)           estado_d = siguiente_campo(estado_q);
      end
      default: estado_d = RUN;
    endcase
    cambio = (estado_d != estado_q);
  end

  // Idle timeout, cursor blink and the registered output values.
  always_comb begin
    timeout_d = timeout_q;
    blink_d   = blink_q;
    cursor_d  = cursor_q;
    forma_d   = forma_q;
    if (ev_fmt) forma_d = (forma_q == FORMA_24H) ? FORMA_12H : FORMA_24H;

    if (estado_d == RUN || cambio) begin
      timeout_d = '0;
    end else if (ev_prog || ev_next || ev_up || ev_down || ev_fmt || disp_up || disp_down) begin
      timeout_d = '0;
    end else begin
      timeout_d = timeout_q + TO_W'(1);
    end

    if (estado_d == RUN) begin
      blink_d  = '0;
      cursor_d = 1'b0;
    end else if (cambio) begin
      blink_d  = '0;
      cursor_d = 1'b1;
    end else if (blink_q == BL_FIN) begin
      blink_d  = '0;
      cursor_d = ~cursor_q;
    end else begin
      blink_d = blink_q + BL_W'(1);
    end

    run_d     = (estado_d == RUN);
    en_hora_d = (estado_d == SET_HORA);
    en_min_d  = (estado_d == SET_MIN);
    en_seg_d  = (estado_d == SET_SEG);
    up_d      = disp_up;
    down_d    = disp_down;
  end

  // State, edge-detect history and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= RUN;
      prev_prog_q <= 1'b1;
      prev_next_q <= 1'b1;
      prev_fmt_q  <= 1'b1;
      timeout_q   <= '0;
      blink_q     <= '0;
      run_q       <= 1'b1;
      en_hora_q   <= 1'b0;
      en_min_q    <= 1'b0;
      en_seg_q    <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      forma_q     <= FORMA_24H;
      cursor_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      prev_prog_q <= prev_prog_d;
      prev_next_q <= prev_next_d;
      prev_fmt_q  <= prev_fmt_d;
      timeout_q   <= timeout_d;
      blink_q     <= blink_d;
      run_q       <= run_d;
      en_hora_q   <= en_hora_d;
      en_min_q    <= en_min_d;
      en_seg_q    <= en_seg_d;
      up_q        <= up_d;
      down_q      <= down_d;
      forma_q     <= forma_d;
      cursor_q    <= cursor_d;
    end
  end

  assign run     = run_q;
  assign en_hora = en_hora_q;
  assign en_min  = en_min_q;
  assign en_seg  = en_seg_q;
  assign up      = up_q;
  assign down    = down_q;
  assign forma   = forma_q;
  assign cursor  = cursor_q;

endmodule

// File: tb/tb_control_edicion_hora.sv
// Bench for control_edicion_hora: directed scenarios followed by random
// button activity, all compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_control_edicion_hora;

  localparam int RD = 8;
  localparam int RR = 4;
  localparam int TO = 50;
  localparam int BH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_prog = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_formato = 1'b0;
  logic run, en_hora, en_min, en_seg, up, down, forma, cursor;

  int checks = 0;
  int errors = 0;

  control_edicion_hora #(
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .TIMEOUT      (TO),
    .BLINK_HALF   (BH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_prog    (btn_prog),
    .btn_next    (btn_next),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_formato (btn_formato),
    .run         (run),
    .en_hora     (en_hora),
    .en_min      (en_min),
    .en_seg      (en_seg),
    .up          (up),
    .down        (down),
    .forma       (forma),
    .cursor      (cursor)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Button bit positions inside a 5-bit stimulus word.
  localparam logic [4:0] B_PROG = 5'b10000;
  localparam logic [4:0] B_NEXT = 5'b01000;
  localparam logic [4:0] B_UP   = 5'b00100;
  localparam logic [4:0] B_DOWN = 5'b00010;
  localparam logic [4:0] B_FMT  = 5'b00001;
  localparam logic [4:0] B_NONE = 5'b00000;

  // Behavioural model: mode 0 = RUN, 1 = hour, 2 = minute, 3 = second.
  int         m_mode;
  bit         m_forma;
  bit [4:0]   m_prev;
  bit         m_arm_up, m_arm_dn;
  int         m_age_up, m_age_dn;
  int         m_idle, m_since;
  logic [7:0] exp_out;

  function automatic void modelReset();
    m_mode   = 0;
    m_forma  = 1'b0;
    m_prev   = 5'b11111;
    m_arm_up = 1'b0;
    m_arm_dn = 1'b0;
    m_age_up = 0;
    m_age_dn = 0;
    m_idle   = 0;
    m_since  = 0;
    exp_out  = 8'b1000_0000;
  endfunction

  // A held step button pulses at press age 0, RD, RD+RR, RD+2RR, ...
  task automatic repeatModel(input bit inhibit, input bit ev, input bit lvl,
                             inout bit arm, inout int age, output bit pulse);
    pulse = 1'b0;
    if (inhibit) begin
      arm = 1'b0;
      age = 0;
    end else if (ev) begin
      arm   = 1'b1;
      age   = 0;
      pulse = 1'b1;
    end else if (!lvl) begin
      arm = 1'b0;
      age = 0;
    end else if (arm) begin
      age   = age + 1;
      pulse = (age >= RD) && (((age - RD) % RR) == 0);
    end
  endtask

  task automatic modelStep();
    bit [4:0] b, ev;
    int nm;
    bit changed, p_up, p_dn, cur;
    b  = {btn_prog, btn_next, btn_up, btn_down, btn_formato};
    ev = b & ~m_prev;
    nm = m_mode;
    if (m_mode == 0) begin
      if (ev[4]) nm = 1;
    end else if (ev[4] || m_idle == TO - 1) begin
      nm = 0;
    end else if (ev[3]) begin
      nm = (m_mode == 3) ? 1 : m_mode + 1;
    end
    changed = (nm != m_mode);
    repeatModel(m_mode == 0 || changed || (b[2] && b[1]), ev[2], b[2], m_arm_up, m_age_up, p_up);
    repeatModel(m_mode == 0 || changed || (b[2] && b[1]), ev[1], b[1], m_arm_dn, m_age_dn, p_dn);
    if (nm == 0 || changed || ev != 5'b0 || p_up || p_dn) m_idle = 0;
    else m_idle = m_idle + 1;
    m_since = changed ? 0 : m_since + 1;
    cur     = (nm != 0) && (((m_since / BH) % 2) == 0);
    m_forma = m_forma ^ ev[0];
    m_prev  = b;
    m_mode  = nm;
    exp_out = {nm == 0, nm == 1, nm == 2, nm == 3, p_up, p_dn, m_forma, cur};
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] obs;
    obs = {run, en_hora, en_min, en_seg, up, down, forma, cursor};
    checks++;
    assert (obs === exp_out) else begin
      errors++;
      $error("[TB] FAIL %s observed={run,eh,em,es,up,dn,forma,cur}=%b expected=%b", tag, obs, exp_out);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Drive one cycle of buttons away from the edge, step the model at the edge, check after it.
  task automatic applyStimulus(input logic [4:0] b, input string tag);
    {btn_prog, btn_next, btn_up, btn_down, btn_formato} = b;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic press(input logic [4:0] b, input string tag);
    applyStimulus(b, tag);
    applyStimulus(B_NONE, {tag, "_rel"});
  endtask

  // Runaway guard.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] up_mask;
    logic        any_step;
    logic [4:0]  rb;

    // Reset state.
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(B_NONE, "idle_run");

    // 1: enter editing, cycle through the fields.
    applyStimulus(B_PROG, "prog_enter");
    checkBit("prog_en_hora", en_hora, 1'b1);
    checkBit("prog_run", run, 1'b0);
    checkBit("prog_cursor", cursor, 1'b1);
    applyStimulus(B_NONE, "prog_rel");
    applyStimulus(B_NEXT, "next1");
    checkBit("next1_en_min", en_min, 1'b1);
    applyStimulus(B_NONE, "next1_rel");
    applyStimulus(B_NEXT, "next2");
    checkBit("next2_en_seg", en_seg, 1'b1);
    applyStimulus(B_NONE, "next2_rel");
    applyStimulus(B_NEXT, "next3");
    checkBit("next3_en_hora", en_hora, 1'b1);
    applyStimulus(B_NONE, "next3_rel");
    press(B_NEXT, "to_min");

    // 2: hold up for 20 cycles in the minute field.
    up_mask = '0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(B_UP, "hold_up");
      up_mask[i + 1] = up;
    end
    for (int i = 20; i < 26; i++) begin
      applyStimulus(B_NONE, "after_up");
      up_mask[i + 1] = up;
    end
    checkBit("up_mask_match", up_mask === 32'h0002_2202, 1'b1);

    // 3: both step buttons held, then a press while running.
    any_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(B_UP | B_DOWN, "both_held");
      any_step = any_step | up | down;
    end
    checkBit("both_no_pulse", any_step, 1'b0);
    applyStimulus(B_NONE, "both_rel");
    press(B_PROG, "to_run");
    checkBit("to_run_run", run, 1'b1);
    any_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(B_UP, "run_up");
      any_step = any_step | up;
    end
    checkBit("run_up_no_pulse", any_step, 1'b0);
    applyStimulus(B_NONE, "run_up_rel");

    // 4: idle timeout in the second field, then prog and next together.
    press(B_PROG, "t4_enter");
    press(B_NEXT, "t4_min");
    applyStimulus(B_NEXT, "t4_seg");
    for (int i = 1; i < TO; i++) applyStimulus(B_NONE, "idle_wait");
    checkBit("timeout_edge_minus1", en_seg, 1'b1);
    applyStimulus(B_NONE, "timeout_hit");
    checkBit("timeout_run", run, 1'b1);
    checkBit("timeout_en_seg", en_seg, 1'b0);
    checkBit("timeout_cursor", cursor, 1'b0);
    press(B_PROG, "t4b_enter");
    applyStimulus(B_PROG | B_NEXT, "prog_next_same");
    checkBit("prog_over_next", run, 1'b1);
    applyStimulus(B_NONE, "prog_next_rel");

    // 5: format toggles in RUN and while editing, then reset mid-edit.
    applyStimulus(B_FMT, "fmt_run");
    checkBit("fmt_run_1", forma, 1'b1);
    applyStimulus(B_NONE, "fmt_run_rel");
    press(B_PROG, "t5_enter");
    press(B_NEXT, "t5_min");
    applyStimulus(B_FMT, "fmt_min");
    checkBit("fmt_min_0", forma, 1'b0);
    applyStimulus(B_NONE, "fmt_min_rel");
    press(B_FMT, "fmt_again");
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("async_reset");
    checkBit("async_reset_forma", forma, 1'b0);

    // 6: prog held through reset release is not a press.
    btn_prog = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(B_PROG, "prog_held");
    checkBit("held_stays_run", run, 1'b1);
    applyStimulus(B_NONE, "held_rel");
    applyStimulus(B_PROG, "held_repress");
    checkBit("repress_en_hora", en_hora, 1'b1);
    applyStimulus(B_NONE, "repress_rel");

    // Random button activity with slowly changing levels.
    rb = B_NONE;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) rb[4] = ~rb[4];
      if ($urandom_range(0, 11) == 0) rb[3] = ~rb[3];
      if ($urandom_range(0, 7)  == 0) rb[2] = ~rb[2];
      if ($urandom_range(0, 9)  == 0) rb[1] = ~rb[1];
      if ($urandom_range(0, 19) == 0) rb[0] = ~rb[0];
      applyStimulus(rb, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
